// File: rtl/ooo_result_writeback_pkg.sv
// ---------------------------------------------------------------------------
// ooo_result_writeback_pkg
// Shared types for the execute-side writeback/bypass block.
//   NUM_FU      : number of functional units feeding writeback
//   DATA_W      : result width
//   fu_idx_t    : fixed unit index order (ALU, MUL, DIV, LSU)
//   wb_entry_t  : one holding register {valid, rd, data}
// ---------------------------------------------------------------------------
package ooo_result_writeback_pkg;

  localparam int NUM_FU = 4;
  localparam int DATA_W = 32;
  localparam int RD_W   = 5;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [RD_W-1:0]   reg_idx_t;

  typedef enum logic [1:0] {
    FU_ALU = 2'd0,
    FU_MUL = 2'd1,
    FU_DIV = 2'd2,
    FU_LSU = 2'd3
  } fu_idx_t;

  typedef struct packed {
    logic     valid;
    reg_idx_t rd;
    word_t    data;
  } wb_entry_t;

endpackage

// File: rtl/ooo_result_writeback_if.sv
// ---------------------------------------------------------------------------
// ooo_bypass_unit_if
// Per-unit bypass bus between the execute-side writeback block (producer)
// and the issue/operand logic (consumer).
//   rd_x    : destination register of the held result of unit x
//   valid_x : holding register of unit x is occupied
//   data_x  : held result of unit x
// Modports: execute (master, drives the bus), issue (slave, observes it).
// ---------------------------------------------------------------------------
interface ooo_bypass_unit_if;
  import ooo_result_writeback_pkg::*;

  reg_idx_t rd_alu;
  reg_idx_t rd_mul;
  reg_idx_t rd_div;
  reg_idx_t rd_lsu;
  logic     valid_alu;
  logic     valid_mul;
  logic     valid_div;
  logic     valid_lsu;
  word_t    data_alu;
  word_t    data_mul;
  word_t    data_div;
  word_t    data_lsu;

  modport execute (
    output rd_alu, rd_mul, rd_div, rd_lsu,
    output valid_alu, valid_mul, valid_div, valid_lsu,
    output data_alu, data_mul, data_div, data_lsu
  );

  modport issue (
    input rd_alu, rd_mul, rd_div, rd_lsu,
    input valid_alu, valid_mul, valid_div, valid_lsu,
    input data_alu, data_mul, data_div, data_lsu
  );

endinterface

// File: rtl/ooo_result_writeback_rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Round-robin arbiter: grants the first requester at or after the pointer,
// wrapping modulo N. The pointer moves past the winner only when adv_i is
// high and a grant was made.
//   clk, rst     : clock, asynchronous active-high reset (pointer -> 0)
//   req_i        : request vector
//   adv_i        : allow the pointer to advance this cycle
//   grant_o      : one-hot grant (zero when no request)
//   grant_idx_o  : index of the granted requester (zero when no request)
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int N     = 4,
  parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     req_i,
  input  logic             adv_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grant_idx_o
);

  logic [IDX_W-1:0] ptr_q;
  logic [IDX_W-1:0] ptr_d;

  // Search requesters starting at the pointer; first hit wins.
  always_comb begin
    int  idx;
    logic found;
    grant_o     = '0;
    grant_idx_o = '0;
    found       = 1'b0;
    idx         = 0;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req_i[idx]) begin
        found        = 1'b1;
        grant_o[idx] = 1'b1;
        grant_idx_o  = IDX_W'(idx);
      end else begin
        found = found;
      end
    end
  end

  // Next pointer: one past the winner, held when nothing was granted.
  always_comb begin
    ptr_d = ptr_q;
    if (adv_i && (|req_i)) begin
      if (grant_idx_o == IDX_W'(N - 1)) begin
        ptr_d = '0;
      end else begin
        ptr_d = grant_idx_o + IDX_W'(1);
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/ooo_result_writeback.sv
// ---------------------------------------------------------------------------
// ooo_result_writeback
// Collects completed ALU/MUL/DIV/LSU results into one-entry holding
// registers, exposes them on the bypass bus, and retires one per cycle to
// the register file via a round-robin arbiter.
//   clk, rst    : clock, asynchronous active-high reset
//   flush_i     : drop all held and incoming results
//   fu_valid_i  : unit i presents a completed result
//   fu_rd_i     : destination register per unit
//   fu_data_i   : result per unit
//   fu_ready_o  : holding register i can accept this cycle
//   bypass      : per-unit rd/valid/data (execute modport)
//   wb_en_o     : register-file write enable
//   wb_rd_o     : register-file write address
//   wb_data_o   : register-file write data
// ---------------------------------------------------------------------------
module ooo_result_writeback
  import ooo_result_writeback_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush_i,
  input  logic [NUM_FU-1:0]             fu_valid_i,
  input  logic [NUM_FU-1:0][RD_W-1:0]   fu_rd_i,
  input  logic [NUM_FU-1:0][DATA_W-1:0] fu_data_i,
  output logic [NUM_FU-1:0]             fu_ready_o,
  ooo_bypass_unit_if.execute            bypass,
  output logic                          wb_en_o,
  output reg_idx_t                      wb_rd_o,
  output word_t                         wb_data_o
);

  wb_entry_t         entry_q [NUM_FU];
  wb_entry_t         entry_d [NUM_FU];
  logic [NUM_FU-1:0] held_s;
  logic [NUM_FU-1:0] grant_s;
  logic [1:0]        grant_idx_s;

  // Occupancy vector doubles as the arbiter request.
  always_comb begin
    held_s = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      held_s[i] = entry_q[i].valid;
    end
  end

  // The pointer must not move on a flush cycle since nothing is written.
  rr_arbiter #(.N(NUM_FU)) u_arb (
    .clk         (clk),
    .rst         (rst),
    .req_i       (held_s),
    .adv_i       (!flush_i),
    .grant_o     (grant_s),
    .grant_idx_o (grant_idx_s)
  );

  // Ready: empty slot, or slot being retired this cycle (same-cycle refill).
  always_comb begin
    fu_ready_o = '0;
    for (int i = 0; i < NUM_FU; i++) begin
      fu_ready_o[i] = !flush_i && (!held_s[i] || grant_s[i]);
    end
  end

  // Holding-register next state: flush > capture > retire > hold.
  always_comb begin
    for (int i = 0; i < NUM_FU; i++) begin
      entry_d[i] = entry_q[i];
      if (flush_i) begin
        entry_d[i] = '0;
      end else if (fu_valid_i[i] && fu_ready_o[i]) begin
        // x0 results are accepted but never held.
        if (fu_rd_i[i] != 5'd0) begin
          entry_d[i].valid = 1'b1;
          entry_d[i].rd    = fu_rd_i[i];
          entry_d[i].data  = fu_data_i[i];
        end else begin
          entry_d[i] = '0;
        end
      end else if (grant_s[i]) begin
        entry_d[i] = '0;
      end else begin
        entry_d[i] = entry_q[i];
      end
    end
  end

  // Holding registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        entry_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        entry_q[i] <= entry_d[i];
      end
    end
  end

  // Register-file write port driven only from held state and the grant.
  always_comb begin
    wb_en_o   = (|held_s) && !flush_i;
    wb_rd_o   = '0;
    wb_data_o = '0;
    if (wb_en_o) begin
      wb_rd_o   = entry_q[grant_idx_s].rd;
      wb_data_o = entry_q[grant_idx_s].data;
    end else begin
      wb_rd_o   = '0;
      wb_data_o = '0;
    end
  end

  // Bypass bus mirrors the holding registers.
  always_comb begin
    bypass.valid_alu = entry_q[FU_ALU].valid;
    bypass.valid_mul = entry_q[FU_MUL].valid;
    bypass.valid_div = entry_q[FU_DIV].valid;
    bypass.valid_lsu = entry_q[FU_LSU].valid;
    bypass.rd_alu    = entry_q[FU_ALU].rd;
    bypass.rd_mul    = entry_q[FU_MUL].rd;
    bypass.rd_div    = entry_q[FU_DIV].rd;
    bypass.rd_lsu    = entry_q[FU_LSU].rd;
    bypass.data_alu  = entry_q[FU_ALU].data;
    bypass.data_mul  = entry_q[FU_MUL].data;
    bypass.data_div  = entry_q[FU_DIV].data;
    bypass.data_lsu  = entry_q[FU_LSU].data;
  end

endmodule

// File: tb/tb_ooo_result_writeback.sv
// ---------------------------------------------------------------------------
// tb_ooo_result_writeback
// Directed bench for ooo_result_writeback with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are checked
// 2 time units after the rising edge.
// ---------------------------------------------------------------------------
module tb_ooo_result_writeback;
  import ooo_result_writeback_pkg::*;

  logic                          clk;
  logic                          rst;
  logic                          flush;
  logic [NUM_FU-1:0]             fu_valid;
  logic [NUM_FU-1:0][RD_W-1:0]   fu_rd;
  logic [NUM_FU-1:0][DATA_W-1:0] fu_data;
  logic [NUM_FU-1:0]             fu_ready;
  logic                          wb_en;
  reg_idx_t                      wb_rd;
  word_t                         wb_data;

  int total;
  int bad;

  ooo_bypass_unit_if byp ();

  ooo_result_writeback dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush),
    .fu_valid_i (fu_valid),
    .fu_rd_i    (fu_rd),
    .fu_data_i  (fu_data),
    .fu_ready_o (fu_ready),
    .bypass     (byp),
    .wb_en_o    (wb_en),
    .wb_rd_o    (wb_rd),
    .wb_data_o  (wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush    = 1'b0;
    fu_valid = '0;
    fu_rd    = '0;
    fu_data  = '0;
  endtask

  task automatic put(input int i, input logic [4:0] rd, input logic [31:0] d);
    fu_valid[i] = 1'b1;
    fu_rd[i]    = rd;
    fu_data[i]  = d;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_no_valid(input string tag);
    check_val(tag, {byp.valid_lsu, byp.valid_div, byp.valid_mul, byp.valid_alu}, 64'h0);
  endtask

  logic [31:0] alu_stream [6];
  logic [31:0] exp_wb     [6];
  logic [4:0]  exp_rd     [6];
  logic        exp_rdy    [6];

  initial begin
    total = 0;
    bad   = 0;
    idle();
    rst = 1'b0;

    // ---------------- reset state
    do_reset();
    #1;
    check_val("rst_ready", fu_ready, 64'hF);
    check_val("rst_wb_en", wb_en, 64'h0);
    check_val("rst_wb_rd", wb_rd, 64'h0);
    check_val("rst_wb_data", wb_data, 64'h0);
    check_no_valid("rst_valid");
    check_val("rst_rd_alu", byp.rd_alu, 64'h0);

    // ---------------- single ALU result
    put(0, 5'd5, 32'hDEADBEEF);
    #1;
    check_val("t1_c0_wb_en", wb_en, 64'h0);
    tick();
    idle();
    #1;
    check_val("t1_c1_valid_alu", byp.valid_alu, 64'h1);
    check_val("t1_c1_rd_alu", byp.rd_alu, 64'd5);
    check_val("t1_c1_data_alu", byp.data_alu, 64'hDEADBEEF);
    check_val("t1_c1_wb_en", wb_en, 64'h1);
    check_val("t1_c1_wb_rd", wb_rd, 64'd5);
    check_val("t1_c1_wb_data", wb_data, 64'hDEADBEEF);
    tick();
    #1;
    check_val("t1_c2_valid_alu", byp.valid_alu, 64'h0);
    check_val("t1_c2_wb_en", wb_en, 64'h0);

    // ---------------- all four at once, pointer starts at 0
    do_reset();
    for (int i = 0; i < NUM_FU; i++) put(i, 5'(i + 1), 32'h100 + 32'(i));
    tick();
    idle();
    #1;
    exp_rdy[0] = 1'b0;
    for (int c = 0; c < 4; c++) begin
      check_val($sformatf("t2_wb_en_%0d", c), wb_en, 64'h1);
      check_val($sformatf("t2_wb_rd_%0d", c), wb_rd, 64'(c + 1));
      check_val($sformatf("t2_wb_data_%0d", c), wb_data, 64'h100 + 64'(c));
      // Ready mask grows by one unit each cycle: 0001, 0011, 0111, 1111.
      check_val($sformatf("t2_ready_%0d", c), fu_ready, 64'((1 << (c + 1)) - 1));
      tick();
      #1;
    end
    check_val("t2_wb_en_drain", wb_en, 64'h0);
    // Pointer back at 0: ALU wins over DIV.
    idle();
    put(0, 5'd10, 32'hA);
    put(2, 5'd11, 32'hB);
    tick();
    idle();
    #1;
    check_val("t2_ptr_first", wb_rd, 64'd10);
    tick();
    #1;
    check_val("t2_ptr_second", wb_rd, 64'd11);

    // ---------------- ALU streaming vs LSU held
    do_reset();
    alu_stream = '{32'hA0, 32'hA1, 32'hA2, 32'hA2, 32'hA3, 32'h0};
    exp_wb     = '{32'h0, 32'hA0, 32'h99, 32'hA1, 32'hA2, 32'hA3};
    exp_rd     = '{5'd0, 5'd7, 5'd9, 5'd7, 5'd7, 5'd7};
    exp_rdy    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    put(0, 5'd7, alu_stream[0]);
    put(3, 5'd9, 32'h99);
    for (int c = 1; c < 6; c++) begin
      tick();
      idle();
      if (c < 5) put(0, 5'd7, alu_stream[c]);
      #1;
      check_val($sformatf("t3_wb_rd_%0d", c), wb_rd, 64'(exp_rd[c]));
      check_val($sformatf("t3_wb_data_%0d", c), wb_data, 64'(exp_wb[c]));
      if (c < 5) check_val($sformatf("t3_ready_alu_%0d", c), fu_ready[0], 64'(exp_rdy[c]));
    end
    tick();
    #1;
    check_val("t3_drained", wb_en, 64'h0);

    // ---------------- rd = 0 result
    do_reset();
    put(0, 5'd0, 32'h1234);
    #1;
    check_val("t4_ready", fu_ready[0], 64'h1);
    tick();
    idle();
    #1;
    check_no_valid("t4_valid");
    check_val("t4_wb_en_c1", wb_en, 64'h0);
    tick();
    #1;
    check_val("t4_wb_en_c2", wb_en, 64'h0);

    // ---------------- flush with three held and DIV arriving
    do_reset();
    put(0, 5'd1, 32'h11);
    put(1, 5'd2, 32'h22);
    put(3, 5'd4, 32'h44);
    tick();
    idle();
    flush = 1'b1;
    put(2, 5'd3, 32'h33);
    #1;
    check_val("t5_flush_wb_en", wb_en, 64'h0);
    check_val("t5_flush_ready", fu_ready, 64'h0);
    tick();
    idle();
    #1;
    check_no_valid("t5_after_valid");
    check_val("t5_after_wb_en", wb_en, 64'h0);
    check_val("t5_after_ready", fu_ready, 64'hF);
    // Pointer unchanged at 0: ALU before LSU.
    put(0, 5'd5, 32'h55);
    put(3, 5'd6, 32'h66);
    tick();
    idle();
    #1;
    check_val("t5_ptr_first", wb_rd, 64'd5);
    tick();
    #1;
    check_val("t5_ptr_second", wb_rd, 64'd6);

    // ---------------- asynchronous reset mid-cycle
    do_reset();
    put(0, 5'd8, 32'h88);
    put(1, 5'd9, 32'h99);
    tick();
    idle();
    #1;
    check_val("t6_pre_wb_en", wb_en, 64'h1);
    rst = 1'b1;
    #1;
    check_no_valid("t6_rst_valid");
    check_val("t6_rst_wb_en", wb_en, 64'h0);
    check_val("t6_rst_wb_rd", wb_rd, 64'h0);
    check_val("t6_rst_ready", fu_ready, 64'hF);
    #1;
    rst = 1'b0;
    tick();
    put(0, 5'd12, 32'hC0FFEE);
    tick();
    idle();
    #1;
    check_val("t6_post_wb_en", wb_en, 64'h1);
    check_val("t6_post_wb_rd", wb_rd, 64'd12);
    check_val("t6_post_wb_data", wb_data, 64'hC0FFEE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ooo_result_writeback.md
Name: ooo_result_writeback

Overview:
- Execute-side producer for the bypass path and sole owner of the register-file write port.
- Collects completed results from the ALU, MUL, DIV and LSU functional units into one-entry holding registers.
- Drives the per-unit rd/valid/data signals of the bypass interface's execute modport from those registers.
- Retires one held result per cycle to the register file through a round-robin arbiter, back-pressuring each unit with a ready signal.

Parameters:
- NUM_FU, 4, number of functional units; index order fixed as ALU=0, MUL=1, DIV=2, LSU=3 (fu_idx_t in package).
- DATA_W, 32, result width (word_t).

Ports:
- CLK  in  1  clock.
- RST  in  1  asynchronous active-high reset.
- flush  in  1  discard all held and incoming results (mispredict/exception).
- fu_valid  in  NUM_FU  unit i presents a completed result.
- fu_rd  in  NUM_FU x 5  destination register per unit.
- fu_data  in  NUM_FU x DATA_W  result per unit.
- fu_ready  out  NUM_FU  holding register i can accept this cycle.
- rd_alu, rd_mul, rd_div, rd_lsu  out  5 each  bypass destination (execute modport).
- valid_alu, valid_mul, valid_div, valid_lsu  out  1 each  bypass entry valid.
- data_alu, data_mul, data_div, data_lsu  out  DATA_W each  bypass data.
- wb_en  out  1  register-file write enable.
- wb_rd  out  5  register-file write address.
- wb_data  out  DATA_W  register-file write data.

Behaviour:
- Per unit i: holding register {held[i], rd[i], data[i]}.
- Reset: all held cleared, rd/data zero, round-robin pointer = 0; all outputs 0 except fu_ready = all ones.
- Handshake: transfer when fu_valid[i] && fu_ready[i], captured on the rising edge.
  - fu_ready[i] = !held[i] || grant[i] (same-cycle refill after retire).
  - fu_ready is combinational from state and grant; it does not depend on fu_valid.
- rd = 0: transfer accepted (ready honoured) but nothing is held; no write, no bypass.
- Bypass outputs:
  - valid_x = held[x]; rd_x and data_x = holding register.
  - Stay valid through the cycle in which the entry is written back.
  - Latency: unit completes at cycle N → bypass valid at N+1 → earliest write at N+1 (register file visible N+2).
- Arbitration:
  - Every cycle with at least one held entry, grant exactly one.
  - Round-robin from pointer p: the first held index in order p, p+1, …, wrapping modulo NUM_FU.
  - After a grant to index g, p = (g+1) mod NUM_FU; otherwise p is unchanged.
- Writeback: wb_en = |held && !flush; wb_rd/wb_data = granted entry; registered path, with no combinational path from fu_* to wb_*.
- Retire: held[g] clears on the edge, unless a new transfer into g happens in the same cycle, in which case the new result is loaded.
- Flush:
  - Combinationally forces wb_en = 0 and fu_ready = 0.
  - Clears all held on the edge; p unchanged.
  - Flush wins over simultaneous capture and retire.
- Fairness: any held entry is written within NUM_FU cycles.
- Ordering: issue logic guarantees at most one in-flight result per rd; this block does no same-rd ordering and does not detect collisions.
- Reset mid-operation: held entries are lost immediately (asynchronous); no write occurs in the reset cycle.

Decomposition:
- rv32i_types_pkg (or a companion ooo package):
  - fu_idx_t enum {FU_ALU, FU_MUL, FU_DIV, FU_LSU}.
  - NUM_FU constant.
  - wb_entry_t struct {logic valid; logic [4:0] rd; word_t data}.
- Sub-module: rr_arbiter (NUM_FU requests, pointer state, one-hot grant, grant_idx), reusable by the issue stage.
- Top-level connection: the bypass outputs connect to ooo_bypass_unit_if.execute.

Test Plan:
- Single ALU result (rd=5, data=0xDEADBEEF) at cycle 0 → valid_alu=1 with rd_alu=5 at cycle 1; wb_en=1, wb_rd=5, wb_data=0xDEADBEEF at cycle 1; valid_alu=0 at cycle 2.
- All four units valid at once (rd 1,2,3,4), p=0 → writes in order rd 1,2,3,4 on consecutive cycles.
  - fu_ready for MUL/DIV/LSU = 0 until granted; p returns to 0.
- ALU streams every cycle (rd=7) while LSU holds rd=9, p=0 → LSU is written no later than the 2nd cycle; ALU and LSU alternate; no ALU result is lost.
  - Same-cycle refill: ready stays 1 while the entry is granted.
- Result with rd=0 and data=0x1234 → fu_ready=1; no valid_x; wb_en stays 0.
- Flush with three entries held and a new DIV result arriving → wb_en=0 and all fu_ready=0 that cycle; the next cycle has all valid_x=0 and wb_en=0; the DIV result is not captured.
- RST asserted asynchronously mid-cycle with entries held → all outputs 0 immediately (fu_ready=1); after release the first new result is written normally.
